// File: rtl/uart_pkg.sv
// Shared types and frame-format constants for the UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
    end
  end

  assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART frame receiver with valid/ready output and error pulses.
// Optional even parity bit: define UART_RX_PARITY_EN.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_WRAP = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  rx_state_e              state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q;
  logic                   dvalid_q, ferr_q, oerr_q, busy_q;
  logic                   done_ok, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d, perr_q, par_bad;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    done_ok   = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_bad   = 1'b0;
`endif
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_s == START_BIT) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          // Re-check the line half a bit in, so short low glitches are dropped.
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_WRAP) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_q == TICK_WRAP) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick_q == TICK_WRAP) begin
            tick_d = '0;
            if (rx_s == STOP_BIT) begin
              state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_q != ^shift_q) par_bad = 1'b1;
              else                   done_ok = 1'b1;
`else
              done_ok = 1'b1;
`endif
            end else begin
              frame_bad = 1'b1;
              state_d   = ST_BRK_WAIT;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (rx_s == LINE_IDLE) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= (state_d != ST_IDLE);
      ferr_q  <= frame_bad;
      oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= par_bad;
`endif
      // A consume in the same cycle frees the slot for the new frame.
      if (done_ok) begin
        if (dvalid_q && !data_ready) begin
          oerr_q <= 1'b1;
        end else begin
          data_q   <= shift_q;
          dvalid_q <= 1'b1;
        end
      end else if (dvalid_q && data_ready) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  assign data_out    = data_q;
  assign data_valid  = dvalid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table-driven frames plus directed corner cases.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun_err, parity_err, busy;

  int checks = 0;
  int failures = 0;
  int n_ferr = 0, n_oerr = 0, n_perr = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  logic last_par;

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // baud_tick every third clock, so idle cycles between ticks are exercised
  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      baud_tick = (cyc % 3 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts error pulses, pops scoreboard on each accepted handshake.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (frame_err)   n_ferr++;
      if (overrun_err) n_oerr++;
      if (parity_err)  n_perr++;
      if (data_valid && data_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0h expected=none", data_out);
        end else begin
          e = sb.pop_front();
          chk("sb_data", {24'd0, data_out}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick_wait(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic drive_head(input logic [7:0] d, input logic p);
    last_par = p;
    rx = 1'b0;
    tick_wait(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick_wait(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    tick_wait(16);
`endif
  endtask

  task automatic drive_stop(input logic stop);
    if (stop) begin
      rx = 1'b1;
      tick_wait(24);
    end else begin
      rx = 1'b0;
      tick_wait(40);
      chk("brk_busy", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      tick_wait(8);
    end
  endtask

  task automatic drain();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", {31'd0, data_valid}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic       push;
    logic       exp_valid;
    logic [7:0] exp_out;
    int         ferr;
    int         oerr;
    logic       drain;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int f0, o0, p0;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 0, 0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data",  {24'd0, data_out}, 32'd0);
    chk("rst_errs",  {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    rst_n = 1'b1;
    tick_wait(4);

    // 0x55: valid exactly one tick-cycle after the stop sample, then held
    data_ready = 1'b0;
    sb.push_back(8'h55);
    drive_head(8'h55, ^8'h55);
    rx = 1'b1;
    tick_wait(8);
    chk("lat_pre",   {31'd0, data_valid}, 32'd0);
    tick_wait(1);
    chk("lat_valid", {31'd0, data_valid}, 32'd1);
    chk("lat_data",  {24'd0, data_out}, 32'h55);
    tick_wait(30);
    chk("hold_valid", {31'd0, data_valid}, 32'd1);
    chk("hold_data",  {24'd0, data_out}, 32'h55);
    drain();

    // start-bit glitch
    f0 = n_ferr; o0 = n_oerr; p0 = n_perr;
    rx = 1'b0;
    tick_wait(4);
    chk("glitch_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick_wait(20);
    chk("glitch_idle",  {31'd0, busy}, 32'd0);
    chk("glitch_valid", {31'd0, data_valid}, 32'd0);
    chk("glitch_errs",  (n_ferr - f0) + (n_oerr - o0) + (n_perr - p0), 32'd0);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      data_ready = vecs[i].ready;
      if (vecs[i].push) sb.push_back(vecs[i].data);
      f0 = n_ferr; o0 = n_oerr;
      drive_head(vecs[i].data, ^vecs[i].data);
      drive_stop(vecs[i].stop);
      chk($sformatf("v%0d_valid", i), {31'd0, data_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_out});
      chk($sformatf("v%0d_ferr", i), n_ferr - f0, vecs[i].ferr);
      chk($sformatf("v%0d_oerr", i), n_oerr - o0, vecs[i].oerr);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      data_ready = 1'b0;
      if (vecs[i].drain) drain();
    end

    // frame completes in the same cycle the pending byte is consumed
    sb.push_back(8'h11);
    drive_head(8'h11, ^8'h11);
    drive_stop(1'b1);
    o0 = n_oerr;
    sb.push_back(8'h3C);
    drive_head(8'h3C, ^8'h3C);
    rx = 1'b1;
    tick_wait(8);
    do @(negedge clk); while (baud_tick !== 1'b1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("same_valid", {31'd0, data_valid}, 32'd1);
    chk("same_data",  {24'd0, data_out}, 32'h3C);
    tick_wait(16);
    chk("same_oerr", n_oerr - o0, 32'd0);
    drain();

    // reset during data bit 3 abandons the frame
    rx = 1'b0;
    tick_wait(16);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      tick_wait(16);
    end
    rx = 1'b0;
    tick_wait(8);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    tick_wait(20);
    chk("midrst_idle_valid", {31'd0, data_valid}, 32'd0);
    f0 = n_ferr;
    sb.push_back(8'h0F);
    drive_head(8'h0F, ^8'h0F);
    drive_stop(1'b1);
    chk("midrst_valid2", {31'd0, data_valid}, 32'd1);
    chk("midrst_data",   {24'd0, data_out}, 32'h0F);
    chk("midrst_ferr",   n_ferr - f0, 32'd0);
    drain();

`ifdef UART_RX_PARITY_EN
    p0 = n_perr;
    drive_head(8'h07, 1'b0);
    drive_stop(1'b1);
    chk("par_bad_perr",  n_perr - p0, 32'd1);
    chk("par_bad_valid", {31'd0, data_valid}, 32'd0);
    sb.push_back(8'h07);
    drive_head(8'h07, 1'b1);
    drive_stop(1'b1);
    chk("par_ok_valid", {31'd0, data_valid}, 32'd1);
    chk("par_ok_data",  {24'd0, data_out}, 32'h07);
    drain();
`else
    chk("no_parity_pulses", n_perr, 32'd0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
